maze_loader: RTL and testbench
==============================

# maze_loader

Bus writer that fills the 64-cell maze memory with a built-in level pattern on request. It sits beside the command block and display driver on the shared tri-state memory bus (address, commend, data). It gains the bus through a request/grant handshake, writes all 64 cells sequentially, and optionally reads them back to verify. The command block uses it to start or restart a level.

## Interface
- `LEVELS`, default 4: number of selectable patterns; `level` wraps modulo LEVELS.
- `MEMORYSIZE` (global define, 2): data width per cell.
- `clk`  input  1: system clock, rising edge.
- `nst`  input  1: reset; one clock; asynchronous, active-low.
- `start`  input  1: one-cycle load request.
- `level`  input  2: pattern select, latched on accepted `start`.
- `bus_req`  output  1: bus request, reset 0.
- `bus_gnt`  input  1: bus grant from the arbiter (command block).
- `address`  output (tri)  6: cell index row*8+col; Z when not granted or idle, reset Z.
- `commend`  output (tri)  1: 1 = write, 0 = read; Z when not driving, reset Z.
- `data`  inout  MEMORYSIZE: driven during writes only; Z otherwise, reset Z.
- `busy`  output  1: high from accepted `start` to `done`, reset 0.
- `done`  output  1: one-cycle pulse at completion, reset 0.
- `error`  output  1: sticky verify mismatch, cleared on next accepted `start`, reset 0.

## Operation
- Cell codes: 0 empty, 1 wall, 2 player, 3 exit.
- Pattern for level n at (r,c): row or col 0/7 -> 1; cell 9 -> 2; cell 54 -> 3; otherwise interior 1 if n≠0 and (r+c+n) mod 4 == 0, else 0.
- States: IDLE, REQ, WRITE, VERIFY (macro only), DONE.
- IDLE: `start`=1 -> latch level, clear `error`, set `busy`, counter=0, go REQ. `start` outside IDLE is ignored.
- REQ: `bus_req`=1; on `bus_gnt`=1 go WRITE.
- WRITE: per granted cycle drive address=counter, commend=1, data=pattern(counter); counter increments. After cell 63 is written, go VERIFY (or DONE); counter wraps to 0.
- VERIFY: per granted cycle drive address=counter, commend=0, data Z; memory returns the cell combinationally. Sample on the same edge and compare with the pattern. Any mismatch sets `error`. After cell 63, go DONE.
- DONE: release bus (all Z, `bus_req`=0), pulse `done`, clear `busy`, go IDLE.
- Grant loss in WRITE/VERIFY: tri-state immediately (combinational on `bus_gnt`), hold counter, keep `bus_req`=1, resume at the same cell on regrant. No cell is skipped or written twice.
- Bus outputs are driven only when `bus_gnt`=1 and state is WRITE/VERIFY.

## Timing
- `start` to `bus_req`: 1 cycle.
- Uninterrupted grant: 64 write cycles, +64 verify cycles if enabled, then 1 DONE cycle. `done` is asserted in the cycle after the last access.
- `start` and `nst` low simultaneously: reset wins.
- Reset mid-operation: bus goes Z and all outputs return to reset values asynchronously. A partial memory image remains.
- `bus_gnt` while not requesting: ignored, bus stays Z.

## Configuration
- `MAZE_LOADER_VERIFY_EN` defined: VERIFY state and the `error` logic are compiled in.
- Undefined: WRITE goes directly to DONE, and `error` is tied 0.

## Test plan
- Reset, then `start`, level=0, grant held -> 64 writes with cell 0=1, cell 9=2, cell 54=3, cell 27=0. `done` pulses 65 cycles after grant (129 with verify). `error`=0.
- Level=1 -> cell 10 (r1,c2; 1+2+1=4) written 1, cell 9 still 2.
- Drop `bus_gnt` for 5 cycles at cell 20 -> bus Z during the gap, resumes at cell 20, exactly 64 writes total.
- Verify enabled, memory model corrupts cell 33 -> `error`=1 after `done`. Next `start` clears it.
- Pulse `nst` low at cell 40 -> bus Z and `busy`=0 immediately, and no `done` pulse occurs. A later `start` runs a full load.
- `start` while `busy` -> ignored, latched level unchanged, single `done`.

Source files
------------

// File: rtl/maze_loader.sv
// Bus writer that fills the 64-cell maze memory with a built-in level pattern.
// Define MAZE_LOADER_VERIFY_EN to add a read-back verify pass and the sticky error flag.
`timescale 1ns/1ps
`ifndef MEMORYSIZE
`define MEMORYSIZE 2
`endif

module maze_loader #(
  parameter int unsigned LEVELS = 4
) (
  input  logic                   clk,
  input  logic                   nst,
  input  logic                   start,
  input  logic [1:0]             level,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output tri   [5:0]             address,
  output tri                     commend,
  inout  tri   [`MEMORYSIZE-1:0] data,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned DW = `MEMORYSIZE;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef MAZE_LOADER_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd4;
`endif

  logic [2:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] lvl_q, lvl_d;
  logic       req_q, req_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef MAZE_LOADER_VERIFY_EN
  logic       err_q, err_d;
`endif

  logic          drv_c;
  logic          wr_c;
  logic [DW-1:0] pat_c;

  // Level pattern: border walls, fixed player/exit, level-dependent interior walls.
  function automatic logic [1:0] cell_code(input logic [5:0] idx, input logic [1:0] n);
    logic [2:0] r;
    logic [2:0] c;
    logic [1:0] s;
    r = idx[5:3];
    c = idx[2:0];
    s = 2'(r) + 2'(c) + n;
    if (r == 3'd0 || r == 3'd7 || c == 3'd0 || c == 3'd7) return 2'd1;
    if (idx == 6'd9)  return 2'd2;
    if (idx == 6'd54) return 2'd3;
    if (n != 2'd0 && s == 2'd0) return 2'd1;
    return 2'd0;
  endfunction

  assign pat_c = DW'(cell_code(cnt_q, lvl_q));
  assign wr_c  = bus_gnt && (state_q == S_WRITE);
`ifdef MAZE_LOADER_VERIFY_EN
  assign drv_c = bus_gnt && (state_q == S_WRITE || state_q == S_VERIFY);
`else
  assign drv_c = wr_c;
`endif

  // Bus released combinationally the moment the grant drops.
  assign address = drv_c ? cnt_q : 6'bz;
  assign commend = drv_c ? wr_c  : 1'bz;
  assign data    = wr_c  ? pat_c : {DW{1'bz}};

  assign bus_req = req_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef MAZE_LOADER_VERIFY_EN
  assign error   = err_q;
`else
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge nst) begin
    if (!nst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      lvl_q   <= 2'd0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MAZE_LOADER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MAZE_LOADER_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    req_d   = req_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MAZE_LOADER_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lvl_d   = 2'(32'(level) % LEVELS);
          cnt_d   = 6'd0;
          req_d   = 1'b1;
          busy_d  = 1'b1;
`ifdef MAZE_LOADER_VERIFY_EN
          err_d   = 1'b0;
`endif
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus_gnt) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
`ifdef MAZE_LOADER_VERIFY_EN
            state_d = S_VERIFY;
`else
            state_d = S_DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef MAZE_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (bus_gnt) begin
          cnt_d = cnt_q + 6'd1;
          if (data != pat_c) err_d = 1'b1;
          if (cnt_q == 6'd63) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_maze_loader.sv
// Scoreboard bench for maze_loader: expected writes queued at start, popped as the bus writes.
`timescale 1ns/1ps
`ifndef MEMORYSIZE
`define MEMORYSIZE 2
`endif

module tb_maze_loader;

  localparam int unsigned DW = `MEMORYSIZE;
`ifdef MAZE_LOADER_VERIFY_EN
  localparam int LAT = 129;
`else
  localparam int LAT = 65;
`endif

  typedef struct packed {
    logic [5:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          nst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    level = 2'd0;
  logic          bus_gnt = 1'b0;
  logic          corrupt = 1'b0;
  wire           bus_req;
  wire           busy;
  wire           done;
  wire           error;
  wire  [5:0]    address;
  wire           commend;
  wire  [DW-1:0] data;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_val;
  wr_t           exp_q [$];
  int            total = 0;
  int            bad = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;

  always #5 clk = ~clk;

  maze_loader #(.LEVELS(4)) dut (
    .clk(clk), .nst(nst), .start(start), .level(level),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .address(address),
    .commend(commend), .data(data), .busy(busy), .done(done), .error(error)
  );

  // Memory answers reads combinationally; cell 33 can be corrupted on demand.
  always_comb rd_val = (corrupt && address == 6'd33) ? ~mem[33] : mem[address];
  assign data = (bus_gnt && commend === 1'b0) ? rd_val : {DW{1'bz}};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_cell(input int a, input int n);
    int r;
    int c;
    r = a / 8;
    c = a % 8;
    if (r == 0 || r == 7 || c == 0 || c == 7) return 1;
    if (a == 9)  return 2;
    if (a == 54) return 3;
    if (n != 0 && (r + c + n) % 4 == 0) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin : mon
    wr_t e;
    if (nst && bus_gnt && commend === 1'b1) begin
      mem[address] = data;
      wr_cnt++;
      chk("wr_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(address), int'(e.a));
        chk("wr_data", int'(data), int'(e.d));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input int n);
    for (int a = 0; a < 64; a++) exp_q.push_back(wr_t'{6'(a), DW'(model_cell(a, n % 4))});
  endtask

  task automatic pulse_start(input int lv);
    tick();
    start = 1'b1;
    level = 2'(lv);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 400);
    chk("done_seen", int'(done === 1'b1), 1);
  endtask

  task automatic wait_write(input int a);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(commend === 1'b1 && address == 6'(a)) && k < 300);
    chk("reach_cell", (commend === 1'b1 && address == 6'(a)) ? a : -1, a);
  endtask

  task automatic run_load(input int lv);
    int k;
    push_load(lv);
    pulse_start(lv);
    @(negedge clk);
    chk("req_lat", int'(bus_req), 1);
    wait_done(k);
    chk("done_lat", k, LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int w0;
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_req", int'(bus_req), 0);
    chk("rst_drive", int'(commend === 1'b1), 0);
    tick();
    nst = 1'b1;

    // Grant while idle must not produce bus activity.
    bus_gnt = 1'b1;
    repeat (3) tick();
    chk("idle_gnt_wr", wr_cnt, 0);
    chk("idle_gnt_req", int'(bus_req), 0);

    w0 = wr_cnt;
    run_load(0);
    tick();
    chk("l0_writes", wr_cnt - w0, 64);
    chk("l0_qempty", exp_q.size(), 0);
    chk("l0_cell0", int'(mem[0]), 1);
    chk("l0_cell9", int'(mem[9]), 2);
    chk("l0_cell54", int'(mem[54]), 3);
    chk("l0_cell27", int'(mem[27]), 0);
    chk("l0_busy", int'(busy), 0);
    chk("l0_error", int'(error), 0);

    // Level 1 with a second start while busy that must be ignored.
    w0 = wr_cnt;
    d0 = done_cnt;
    push_load(1);
    pulse_start(1);
    repeat (10) tick();
    chk("busy_mid", int'(busy), 1);
    start = 1'b1;
    level = 2'd3;
    tick();
    start = 1'b0;
    wait_done(k);
    repeat (5) tick();
    chk("l1_done_once", done_cnt - d0, 1);
    chk("l1_writes", wr_cnt - w0, 64);
    chk("l1_cell10", int'(mem[10]), 1);
    chk("l1_cell9", int'(mem[9]), 2);
    chk("l1_busy", int'(busy), 0);

    // Grant drop at cell 20.
    w0 = wr_cnt;
    push_load(2);
    pulse_start(2);
    wait_write(19);
    tick();
    bus_gnt = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("gap_drive", int'(commend === 1'b1), 0);
      chk("gap_req", int'(bus_req), 1);
    end
    tick();
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("resume_addr", int'(address), 20);
    wait_done(k);
    tick();
    chk("gap_writes", wr_cnt - w0, 64);
    chk("gap_qempty", exp_q.size(), 0);

    // Reset in the middle of a load at cell 40.
    push_load(3);
    pulse_start(3);
    wait_write(39);
    tick();
    nst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_req", int'(bus_req), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_drive", int'(commend === 1'b1), 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) tick();
    nst = 1'b1;
    repeat (5) tick();
    chk("mid_rst_nodone", done_cnt - d0, 0);
    w0 = wr_cnt;
    run_load(3);
    tick();
    chk("l3_writes", wr_cnt - w0, 64);
    chk("l3_cell12", int'(mem[12]), 1);
    chk("l3_cell10", int'(mem[10]), 0);

`ifdef MAZE_LOADER_VERIFY_EN
    corrupt = 1'b1;
    run_load(0);
    tick();
    chk("vfy_error_set", int'(error), 1);
    corrupt = 1'b0;
    push_load(0);
    pulse_start(0);
    @(negedge clk);
    chk("vfy_error_clr", int'(error), 0);
    wait_done(k);
    tick();
    chk("vfy_error_clean", int'(error), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
